conflict_serializer_ttype: RTL and testbench

Parametrised next-generation locale serializer between a tile's commit-queue dispatch port and its worker threads. Buffers up to DEPTH dispatched tasks and issues them oldest-eligible-first, so that no two lock-taking tasks with equal locale run at once. New versus the fixed-size serializer:
- issue filtered by a per-request task-type mask;
- per-task "no_lock" bypass;
- generic payload width;
- configuration thresholds on direct ports instead of the register bus.

---
 rtl/conflict_serializer_ttype_if.sv | 43 ++++
 rtl/conflict_serializer_ttype.sv | 232 +++++++++++++++++++++++
 tb/tb_conflict_serializer_ttype.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conflict_serializer_ttype_if.sv
// Enqueue/issue handshake bundle for the locale serializer.
// slave = serializer side, master = dispatch/thread side.
interface conflict_serializer_ttype_if #(
  parameter int DATA_WIDTH   = 64,
  parameter int LOCALE_WIDTH = 32,
  parameter int TTYPE_WIDTH  = 4,
  parameter int SLOT_WIDTH   = 7,
  parameter int TID_WIDTH    = 2
);
  localparam int NT = 2**TTYPE_WIDTH;

  logic                    m_valid;
  logic                    m_ready;
  logic [DATA_WIDTH-1:0]   m_data;
  logic [LOCALE_WIDTH-1:0] m_locale;
  logic [TTYPE_WIDTH-1:0]  m_ttype;
  logic                    m_no_lock;
  logic [SLOT_WIDTH-1:0]   m_slot;

  logic                    s_valid;
  logic                    s_ready;
  logic [NT-1:0]           s_ttype_mask;
  logic [DATA_WIDTH-1:0]   s_data;
  logic [SLOT_WIDTH-1:0]   s_slot;
  logic [LOCALE_WIDTH-1:0] s_locale;
  logic [TID_WIDTH-1:0]    s_thread;

  modport master (
    output m_valid, m_data, m_locale, m_ttype,
    output m_no_lock, m_slot,
    input  m_ready,
    input  s_valid, s_data, s_slot, s_locale, s_thread,
    output s_ready, s_ttype_mask
  );

  modport slave (
    input  m_valid, m_data, m_locale, m_ttype,
    input  m_no_lock, m_slot,
    output m_ready,
    output s_valid, s_data, s_slot, s_locale, s_thread,
    input  s_ready, s_ttype_mask
  );
endinterface

// File: rtl/conflict_serializer_ttype.sv
// Locale serializer: age-ordered ready list, type-masked issue,
// per-locale lock tracking across worker threads.
module conflict_serializer_ttype #(
  parameter int LOG_DEPTH    = 3,
  parameter int N_THREADS    = 4,
  parameter int LOCALE_WIDTH = 32,
  parameter int TTYPE_WIDTH  = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int SLOT_WIDTH   = 7
) (
  input  logic                         clk,
  input  logic                         rstn,
  conflict_serializer_ttype_if.slave   bus,
  input  logic                         unlock_valid,
  input  logic [$clog2(N_THREADS)-1:0] unlock_thread,
  input  logic [LOG_DEPTH:0]           cfg_full_limit,
  input  logic [LOG_DEPTH:0]           cfg_almost_full,
  input  logic [$clog2(N_THREADS):0]   cfg_active_threads,
  output logic                         almost_full,
  output logic [LOG_DEPTH:0]           occupancy,
  output logic                         all_idle
);
  localparam int DEPTH = 2**LOG_DEPTH;
  localparam int TW = $clog2(N_THREADS);
  localparam int LW = LOG_DEPTH;
  localparam int CW = LOG_DEPTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW:0] NTH_C = (TW+1)'(N_THREADS);

  typedef logic [LOCALE_WIDTH-1:0] loc_t;

  logic [DEPTH-1:0] val_q, val_d, cf_q, cf_d;
  logic [DEPTH-1:0] nl_q, nl_d, used_q, used_d;
  loc_t loc_q [DEPTH];
  loc_t loc_d [DEPTH];
  logic [TTYPE_WIDTH-1:0] tt_q [DEPTH];
  logic [TTYPE_WIDTH-1:0] tt_d [DEPTH];
  logic [LW-1:0] id_q [DEPTH];
  logic [LW-1:0] id_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [SLOT_WIDTH-1:0] slot_q [DEPTH];
  logic [SLOT_WIDTH-1:0] slot_d [DEPTH];
  logic [CW-1:0] occ_q, occ_d;

  logic [TW-1:0] tq_q [N_THREADS];
  logic [TW-1:0] tq_d [N_THREADS];
  logic [TW-1:0] thead_q, thead_d, ttail_q, ttail_d;
  logic [TW:0] tcnt_q, tcnt_d;
  logic [N_THREADS-1:0] rv_q, rv_d, rl_q, rl_d;
  loc_t rloc_q [N_THREADS];
  loc_t rloc_d [N_THREADS];

  logic [DEPTH-1:0] elig, cf_tmp;
  logic [LW-1:0] sel, nid, rel_idx;
  logic any_elig, thr_avail, issue, accept;
  logic hit, rel_ok, ul_lock;
  logic [TW+1:0] thr_need;
  logic [CW-1:0] wr;
  loc_t ul_loc;

  assign bus.m_ready = (occ_q < DEPTH_C) && (occ_q < cfg_full_limit);
  assign accept = bus.m_valid & bus.m_ready;
  assign thr_need = {1'b0, NTH_C} - {1'b0, cfg_active_threads};
  assign thr_avail = {1'b0, tcnt_q} > thr_need;
  assign bus.s_valid = any_elig & thr_avail;
  assign issue = bus.s_valid & bus.s_ready;
  assign bus.s_data = data_q[id_q[sel]];
  assign bus.s_slot = slot_q[id_q[sel]];
  assign bus.s_locale = loc_q[sel];
  assign bus.s_thread = tq_q[thead_q];
  assign occupancy = occ_q;
  assign almost_full = occ_q >= cfg_almost_full;
  assign all_idle = (occ_q == '0) && (tcnt_q == NTH_C);
  assign ul_lock = unlock_valid & rv_q[unlock_thread]
                 & rl_q[unlock_thread];
  assign ul_loc = rloc_q[unlock_thread];

  // Pick the oldest entry that is unblocked and of an accepted type
  always_comb begin
    elig = '0;
    sel = '0;
    any_elig = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      elig[i] = val_q[i] & ~cf_q[i]
              & bus.s_ttype_mask[tt_q[i]];
    for (int i = DEPTH - 1; i >= 0; i--)
      if (elig[i]) begin
        sel = LW'(i);
        any_elig = 1'b1;
      end
  end

  // Locale hazards for the incoming task, unlock release, free id
  always_comb begin
    hit = 1'b0;
    rel_ok = 1'b0;
    rel_idx = '0;
    nid = '0;
    if (!bus.m_no_lock) begin
      for (int i = 0; i < DEPTH; i++)
        if (val_q[i] && !nl_q[i] && loc_q[i] == bus.m_locale)
          hit = 1'b1;
      for (int t = 0; t < N_THREADS; t++)
        if (rv_q[t] && rl_q[t] && rloc_q[t] == bus.m_locale
            && !(unlock_valid && unlock_thread == TW'(t)))
          hit = 1'b1;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ul_lock && val_q[i] && !nl_q[i] && cf_q[i]
          && loc_q[i] == ul_loc) begin
        rel_ok = 1'b1;
        rel_idx = LW'(i);
      end
      if (!used_q[i])
        nid = LW'(i);
    end
  end

  // Ready list: release, compact past the issued entry, then append
  always_comb begin
    int src;
    val_d = val_q;
    cf_d = cf_q;
    nl_d = nl_q;
    loc_d = loc_q;
    tt_d = tt_q;
    id_d = id_q;
    data_d = data_q;
    slot_d = slot_q;
    used_d = used_q;
    cf_tmp = cf_q;
    src = 0;
    if (rel_ok)
      cf_tmp[rel_idx] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      src = (issue && i >= int'(sel)) ? i + 1 : i;
      if (src < DEPTH) begin
        val_d[i] = val_q[LW'(src)];
        cf_d[i] = cf_tmp[LW'(src)];
        nl_d[i] = nl_q[LW'(src)];
        loc_d[i] = loc_q[LW'(src)];
        tt_d[i] = tt_q[LW'(src)];
        id_d[i] = id_q[LW'(src)];
      end else begin
        val_d[i] = 1'b0;
      end
    end
    wr = occ_q - CW'(issue);
    if (issue)
      used_d[id_q[sel]] = 1'b0;
    if (accept) begin
      val_d[LW'(wr)] = 1'b1;
      cf_d[LW'(wr)] = hit;
      nl_d[LW'(wr)] = bus.m_no_lock;
      loc_d[LW'(wr)] = bus.m_locale;
      tt_d[LW'(wr)] = bus.m_ttype;
      id_d[LW'(wr)] = nid;
      data_d[nid] = bus.m_data;
      slot_d[nid] = bus.m_slot;
      used_d[nid] = 1'b1;
    end
    occ_d = occ_q + CW'(accept) - CW'(issue);
  end

  // Thread free FIFO and per-thread lock record
  always_comb begin
    tq_d = tq_q;
    rv_d = rv_q;
    rl_d = rl_q;
    rloc_d = rloc_q;
    thead_d = thead_q + TW'(issue);
    ttail_d = ttail_q + TW'(unlock_valid);
    tcnt_d = tcnt_q + (TW+1)'(unlock_valid) - (TW+1)'(issue);
    if (unlock_valid) begin
      tq_d[ttail_q] = unlock_thread;
      rv_d[unlock_thread] = 1'b0;
      rl_d[unlock_thread] = 1'b0;
      rloc_d[unlock_thread] = '0;
    end
    if (issue) begin
      rv_d[bus.s_thread] = 1'b1;
      rl_d[bus.s_thread] = ~nl_q[sel];
      rloc_d[bus.s_thread] = loc_q[sel];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q <= '0;
      cf_q <= '0;
      nl_q <= '0;
      used_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        loc_q[i] <= '0;
        tt_q[i] <= '0;
        id_q[i] <= '0;
        data_q[i] <= '0;
        slot_q[i] <= '0;
      end
      for (int t = 0; t < N_THREADS; t++) begin
        tq_q[t] <= TW'(t);
        rloc_q[t] <= '0;
      end
      thead_q <= '0;
      ttail_q <= '0;
      tcnt_q <= NTH_C;
      rv_q <= '0;
      rl_q <= '0;
    end else begin
      val_q <= val_d;
      cf_q <= cf_d;
      nl_q <= nl_d;
      used_q <= used_d;
      occ_q <= occ_d;
      loc_q <= loc_d;
      tt_q <= tt_d;
      id_q <= id_d;
      data_q <= data_d;
      slot_q <= slot_d;
      tq_q <= tq_d;
      rloc_q <= rloc_d;
      thead_q <= thead_d;
      ttail_q <= ttail_d;
      tcnt_q <= tcnt_d;
      rv_q <= rv_d;
      rl_q <= rl_d;
    end
  end
endmodule

// File: tb/tb_conflict_serializer_ttype.sv
// Directed bench for conflict_serializer_ttype.
// Inputs change on negedge, outputs checked 1ns later.
module tb_conflict_serializer_ttype;
  logic clk = 1'b0;
  logic rstn;
  logic unlock_valid;
  logic [1:0] unlock_thread;
  logic [3:0] cfg_full_limit, cfg_almost_full;
  logic [2:0] cfg_active_threads;
  logic almost_full, all_idle;
  logic [3:0] occupancy;
  int n_vec = 0;
  int n_err = 0;

  conflict_serializer_ttype_if #(
    .DATA_WIDTH(64), .LOCALE_WIDTH(32), .TTYPE_WIDTH(4),
    .SLOT_WIDTH(7), .TID_WIDTH(2)
  ) bus ();

  conflict_serializer_ttype #(
    .LOG_DEPTH(3), .N_THREADS(4), .LOCALE_WIDTH(32),
    .TTYPE_WIDTH(4), .DATA_WIDTH(64), .SLOT_WIDTH(7)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .unlock_valid(unlock_valid), .unlock_thread(unlock_thread),
    .cfg_full_limit(cfg_full_limit),
    .cfg_almost_full(cfg_almost_full),
    .cfg_active_threads(cfg_active_threads),
    .almost_full(almost_full), .occupancy(occupancy),
    .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_m(input logic v, input logic [31:0] loc,
                         input logic [3:0] tt, input logic nl,
                         input logic [63:0] d);
    bus.m_valid = v;
    bus.m_locale = loc;
    bus.m_ttype = tt;
    bus.m_no_lock = nl;
    bus.m_data = d;
    bus.m_slot = d[6:0];
  endtask

  task automatic unlock(input logic [1:0] t);
    unlock_valid = 1'b1;
    unlock_thread = t;
    cyc();
    unlock_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL rst_svalid: got %0h want 0", bus.s_valid); end
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_vec++; if (all_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %0h want 1", all_idle); end
    n_vec++; if (bus.s_thread !== 2'd0) begin n_err++; $display("FAIL rst_thread: got %0d want 0", bus.s_thread); end
    n_vec++; if (bus.m_ready !== 1'b1) begin n_err++; $display("FAIL rst_mready: got %0h want 1", bus.m_ready); end
    n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_af: got %0h want 0", almost_full); end
  endtask

  task automatic test_issue_order();
    bus.s_ready = 1'b1;
    drive_m(1, 5, 0, 0, 64'hA5); cyc();
    drive_m(1, 6, 0, 0, 64'hA6); #1;
    n_vec++; if (bus.s_valid !== 1'b1) begin n_err++; $display("FAIL ord_v0: got %0h want 1", bus.s_valid); end
    n_vec++; if (bus.s_thread !== 2'd0) begin n_err++; $display("FAIL ord_t0: got %0d want 0", bus.s_thread); end
    n_vec++; if (bus.s_data !== 64'hA5) begin n_err++; $display("FAIL ord_d0: got %0h want a5", bus.s_data); end
    n_vec++; if (bus.s_slot !== 7'h25) begin n_err++; $display("FAIL ord_slot0: got %0h want 25", bus.s_slot); end
    cyc();
    drive_m(1, 7, 0, 0, 64'hA7); #1;
    n_vec++; if (bus.s_thread !== 2'd1) begin n_err++; $display("FAIL ord_t1: got %0d want 1", bus.s_thread); end
    n_vec++; if (bus.s_locale !== 32'd6) begin n_err++; $display("FAIL ord_l1: got %0d want 6", bus.s_locale); end
    cyc();
    drive_m(0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.s_thread !== 2'd2) begin n_err++; $display("FAIL ord_t2: got %0d want 2", bus.s_thread); end
    n_vec++; if (bus.s_locale !== 32'd7) begin n_err++; $display("FAIL ord_l2: got %0d want 7", bus.s_locale); end
    n_vec++; if (all_idle !== 1'b0) begin n_err++; $display("FAIL ord_idle: got %0h want 0", all_idle); end
    cyc(); #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL ord_empty: got %0h want 0", bus.s_valid); end
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL ord_occ: got %0d want 0", occupancy); end
    unlock(0); unlock(1); unlock(2);
  endtask

  task automatic test_lock_chain();
    drive_m(1, 5, 0, 0, 64'hB0); cyc();
    drive_m(1, 5, 0, 0, 64'hB1); #1;
    n_vec++; if (bus.s_thread !== 2'd3) begin n_err++; $display("FAIL chain_tx: got %0d want 3", bus.s_thread); end
    cyc();
    drive_m(1, 5, 0, 0, 64'hB2); #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL chain_a_blk: got %0h want 0", bus.s_valid); end
    cyc();
    drive_m(0, 0, 0, 0, 0);
    unlock_valid = 1'b1; unlock_thread = 2'd3; #1;
    n_vec++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL chain_occ2: got %0d want 2", occupancy); end
    cyc();
    unlock_valid = 1'b0; #1;
    n_vec++; if (bus.s_valid !== 1'b1) begin n_err++; $display("FAIL chain_a_v: got %0h want 1", bus.s_valid); end
    n_vec++; if (bus.s_thread !== 2'd0) begin n_err++; $display("FAIL chain_a_t: got %0d want 0", bus.s_thread); end
    n_vec++; if (bus.s_data !== 64'hB1) begin n_err++; $display("FAIL chain_a_d: got %0h want b1", bus.s_data); end
    cyc(); cyc(); #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL chain_b_blk: got %0h want 0", bus.s_valid); end
    unlock(0);
    n_vec++; if (bus.s_data !== 64'hB2 || bus.s_valid !== 1'b1) begin n_err++; $display("FAIL chain_b_d: got %0h/%0h want b2/1", bus.s_data, bus.s_valid); end
    n_vec++; if (bus.s_thread !== 2'd1) begin n_err++; $display("FAIL chain_b_t: got %0d want 1", bus.s_thread); end
    cyc();
    unlock(1);
  endtask

  task automatic test_same_cycle_unlock();
    drive_m(1, 5, 0, 0, 64'hC0); cyc();
    drive_m(0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.s_thread !== 2'd2) begin n_err++; $display("FAIL same_ty: got %0d want 2", bus.s_thread); end
    cyc();
    drive_m(1, 5, 0, 0, 64'hC1);
    unlock_valid = 1'b1; unlock_thread = 2'd2;
    cyc();
    drive_m(0, 0, 0, 0, 0); unlock_valid = 1'b0; #1;
    n_vec++; if (bus.s_valid !== 1'b1) begin n_err++; $display("FAIL same_zv: got %0h want 1", bus.s_valid); end
    n_vec++; if (bus.s_thread !== 2'd3) begin n_err++; $display("FAIL same_zt: got %0d want 3", bus.s_thread); end
    n_vec++; if (bus.s_data !== 64'hC1) begin n_err++; $display("FAIL same_zd: got %0h want c1", bus.s_data); end
    cyc();
    unlock(3);
  endtask

  task automatic test_ttype_mask();
    bus.s_ttype_mask = 16'h0008;
    drive_m(1, 20, 2, 0, 64'hD2); cyc();
    drive_m(1, 21, 3, 0, 64'hD3); #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL mask_blk: got %0h want 0", bus.s_valid); end
    cyc();
    drive_m(0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.s_data !== 64'hD3 || bus.s_valid !== 1'b1) begin n_err++; $display("FAIL mask_t3: got %0h/%0h want d3/1", bus.s_data, bus.s_valid); end
    cyc(); #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL mask_t2_blk: got %0h want 0", bus.s_valid); end
    bus.s_ttype_mask = 16'h0004; #1;
    n_vec++; if (bus.s_data !== 64'hD2 || bus.s_valid !== 1'b1) begin n_err++; $display("FAIL mask_t2: got %0h/%0h want d2/1", bus.s_data, bus.s_valid); end
    n_vec++; if (bus.s_thread !== 2'd1) begin n_err++; $display("FAIL mask_t2_thr: got %0d want 1", bus.s_thread); end
    cyc();
    bus.s_ttype_mask = 16'hFFFF;
    unlock(0); unlock(1);
  endtask

  task automatic test_no_lock();
    drive_m(1, 9, 0, 0, 64'hE0); cyc();
    drive_m(1, 9, 0, 1, 64'hE1); #1;
    n_vec++; if (bus.s_thread !== 2'd2) begin n_err++; $display("FAIL nl_h_t: got %0d want 2", bus.s_thread); end
    cyc();
    drive_m(1, 9, 0, 0, 64'hE2); #1;
    n_vec++; if (bus.s_data !== 64'hE1 || bus.s_valid !== 1'b1) begin n_err++; $display("FAIL nl_n1: got %0h/%0h want e1/1", bus.s_data, bus.s_valid); end
    cyc();
    drive_m(1, 9, 0, 1, 64'hE3); #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL nl_l_blk: got %0h want 0", bus.s_valid); end
    cyc();
    drive_m(0, 0, 0, 0, 0); #1;
    n_vec++; if (bus.s_data !== 64'hE3 || bus.s_thread !== 2'd0) begin n_err++; $display("FAIL nl_n2: got %0h/%0d want e3/0", bus.s_data, bus.s_thread); end
    cyc();
    unlock(3);
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL nl_unl_n1: got %0h want 0", bus.s_valid); end
    unlock(0);
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL nl_unl_n2: got %0h want 0", bus.s_valid); end
    unlock(2);
    n_vec++; if (bus.s_data !== 64'hE2 || bus.s_valid !== 1'b1) begin n_err++; $display("FAIL nl_l_rel: got %0h/%0h want e2/1", bus.s_data, bus.s_valid); end
    n_vec++; if (bus.s_thread !== 2'd1) begin n_err++; $display("FAIL nl_l_t: got %0d want 1", bus.s_thread); end
    cyc();
    unlock(1);
  endtask

  task automatic test_full_limit();
    bus.s_ready = 1'b0;
    cfg_full_limit = 4'd3;
    cfg_almost_full = 4'd3;
    drive_m(1, 30, 0, 0, 64'hF0); #1;
    n_vec++; if (bus.m_ready !== 1'b1) begin n_err++; $display("FAIL full_rdy0: got %0h want 1", bus.m_ready); end
    cyc();
    drive_m(1, 31, 0, 0, 64'hF1); cyc();
    drive_m(1, 32, 0, 0, 64'hF2); cyc();
    drive_m(1, 33, 0, 0, 64'hF3); #1;
    n_vec++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL full_occ3: got %0d want 3", occupancy); end
    n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL full_af1: got %0h want 1", almost_full); end
    bus.s_ready = 1'b1; #1;
    n_vec++; if (bus.m_ready !== 1'b0) begin n_err++; $display("FAIL full_rdy_iss: got %0h want 0", bus.m_ready); end
    n_vec++; if (bus.s_valid !== 1'b1) begin n_err++; $display("FAIL full_sv: got %0h want 1", bus.s_valid); end
    cyc();
    drive_m(0, 0, 0, 0, 0); #1;
    n_vec++; if (occupancy !== 4'd2) begin n_err++; $display("FAIL full_occ2: got %0d want 2", occupancy); end
    n_vec++; if (bus.m_ready !== 1'b1 || almost_full !== 1'b0) begin n_err++; $display("FAIL full_rdy_af: got %0h/%0h want 1/0", bus.m_ready, almost_full); end
    cfg_active_threads = 3'd2; #1;
    n_vec++; if (bus.s_valid !== 1'b1 || bus.s_thread !== 2'd0) begin n_err++; $display("FAIL act_2nd: got %0h/%0d want 1/0", bus.s_valid, bus.s_thread); end
    cyc(); #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL act_cap: got %0h want 0", bus.s_valid); end
    unlock(3);
    n_vec++; if (bus.s_data !== 64'hF2 || bus.s_thread !== 2'd2) begin n_err++; $display("FAIL act_free: got %0h/%0d want f2/2", bus.s_data, bus.s_thread); end
    cyc(); #1;
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL act_occ0: got %0d want 0", occupancy); end
    unlock(0); unlock(2);
    cfg_full_limit = 4'd8;
    cfg_almost_full = 4'd6;
    cfg_active_threads = 3'd4;
  endtask

  task automatic test_async_reset();
    bus.s_ready = 1'b0;
    drive_m(1, 40, 0, 0, 64'h11); cyc();
    drive_m(1, 41, 0, 0, 64'h12); #1;
    n_vec++; if (bus.s_thread !== 2'd1 || bus.s_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %0d/%0h want 1/1", bus.s_thread, bus.s_valid); end
    cfg_almost_full = 4'd0;
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (bus.s_valid !== 1'b0) begin n_err++; $display("FAIL ar_sv: got %0h want 0", bus.s_valid); end
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL ar_occ: got %0d want 0", occupancy); end
    n_vec++; if (all_idle !== 1'b1) begin n_err++; $display("FAIL ar_idle: got %0h want 1", all_idle); end
    n_vec++; if (bus.s_thread !== 2'd0) begin n_err++; $display("FAIL ar_thr: got %0d want 0", bus.s_thread); end
    n_vec++; if (bus.m_ready !== 1'b1) begin n_err++; $display("FAIL ar_mr: got %0h want 1", bus.m_ready); end
    n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL ar_af: got %0h want 1", almost_full); end
    drive_m(0, 0, 0, 0, 0);
    cyc();
    rstn = 1'b1;
    cyc(); #1;
    n_vec++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL ar_post: got %0d want 0", occupancy); end
  endtask

  initial begin
    rstn = 1'b0;
    unlock_valid = 1'b0;
    unlock_thread = 2'd0;
    cfg_full_limit = 4'd8;
    cfg_almost_full = 4'd6;
    cfg_active_threads = 3'd4;
    bus.s_ready = 1'b0;
    bus.s_ttype_mask = 16'hFFFF;
    drive_m(0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    test_reset();
    test_issue_order();
    test_lock_chain();
    test_same_cycle_unlock();
    test_ttype_mask();
    test_no_lock();
    test_full_limit();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
